// File: rtl/rf_write_scheduler_pkg.sv
// Shared constants and rotating-priority helpers for the register-file write scheduler.
package rf_write_scheduler_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 5;
  localparam int NUM_SRC_DEF    = 4;
  localparam int PTR_W          = 2;

  typedef logic [PTR_W-1:0] src_idx_t;

  // Index wraps naturally at the 2-bit width, giving modulo-4 rotation.
  function automatic src_idx_t rr_rot(input src_idx_t base, input int ofs);
    return base + src_idx_t'(ofs);
  endfunction

  function automatic src_idx_t rr_next(input src_idx_t idx);
    return rr_rot(idx, 1);
  endfunction

endpackage

// File: rtl/rf_write_scheduler_rr_pick2.sv
// Two-winner rotating-priority picker; the second winner must target a
// different address than the first so the storage never sees a same-address pair.
module rr_pick2
  import rf_write_scheduler_pkg::*;
#(
  parameter int NUM_SRC    = NUM_SRC_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic [NUM_SRC-1:0]                 req,
  input  src_idx_t                           ptr,
  input  logic [NUM_SRC-1:0][ADDR_WIDTH-1:0] addr,
  output logic [NUM_SRC-1:0]                 gnt1,
  output logic [NUM_SRC-1:0]                 gnt2,
  output logic                               vld1,
  output logic                               vld2,
  output src_idx_t                           idx1,
  output src_idx_t                           idx2
);

  logic [ADDR_WIDTH-1:0] addr1;
  src_idx_t              cand;

  always_comb begin
    gnt1  = '0;
    gnt2  = '0;
    vld1  = 1'b0;
    vld2  = 1'b0;
    idx1  = '0;
    idx2  = '0;
    addr1 = '0;
    cand  = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = rr_rot(ptr, k);
      if (req[cand]) begin
        if (!vld1) begin
          vld1       = 1'b1;
          gnt1[cand] = 1'b1;
          idx1       = cand;
          addr1      = addr[cand];
        end else if (!vld2 && (addr[cand] != addr1)) begin
          vld2       = 1'b1;
          gnt2[cand] = 1'b1;
          idx2       = cand;
        end
      end
    end
  end

endmodule

// File: rtl/rf_write_scheduler.sv
// Writer-side front end: one-entry buffer per result source, up to two
// conflict-free register writes per cycle under round-robin priority.
module rf_write_scheduler
  import rf_write_scheduler_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int NUM_SRC    = NUM_SRC_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_SRC-1:0]             src_valid_i,
  output logic [NUM_SRC-1:0]             src_ready_o,
  input  logic [NUM_SRC*ADDR_WIDTH-1:0]  src_addr_i,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]  src_data_i,
  output logic                           wr1_en_o,
  output logic [ADDR_WIDTH-1:0]          wr1_addr_o,
  output logic [DATA_WIDTH-1:0]          wr1_data_o,
  output logic                           wr2_en_o,
  output logic [ADDR_WIDTH-1:0]          wr2_addr_o,
  output logic [DATA_WIDTH-1:0]          wr2_data_o,
  output logic                           busy_o
);

  logic [NUM_SRC-1:0]                 held;
  logic [NUM_SRC-1:0]                 grant;
  logic [NUM_SRC-1:0]                 gnt1;
  logic [NUM_SRC-1:0]                 gnt2;
  logic [NUM_SRC-1:0]                 accept;
  logic [NUM_SRC-1:0][ADDR_WIDTH-1:0] haddr;
  logic [NUM_SRC-1:0][ADDR_WIDTH-1:0] in_addr;
  logic [NUM_SRC-1:0][DATA_WIDTH-1:0] hdata;
  logic [NUM_SRC-1:0][DATA_WIDTH-1:0] in_data;
  src_idx_t                           rr_ptr;
  src_idx_t                           idx1;
  src_idx_t                           idx2;
  logic                               vld1;
  logic                               vld2;

  assign in_addr = src_addr_i;
  assign in_data = src_data_i;

  rr_pick2 #(
    .NUM_SRC    (NUM_SRC),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_pick (
    .req  (held),
    .ptr  (rr_ptr),
    .addr (haddr),
    .gnt1 (gnt1),
    .gnt2 (gnt2),
    .vld1 (vld1),
    .vld2 (vld2),
    .idx1 (idx1),
    .idx2 (idx2)
  );

  always_comb begin
    grant       = gnt1 | gnt2;
    src_ready_o = rst ? '1 : (~held | grant);
    accept      = '0;
    // A result for x0 is consumed at the handshake but never buffered.
    for (int s = 0; s < NUM_SRC; s++) begin
      accept[s] = src_valid_i[s] & src_ready_o[s] & (in_addr[s] != '0);
    end
    wr1_en_o   = vld1 & ~rst;
    wr2_en_o   = vld2 & ~rst;
    wr1_addr_o = wr1_en_o ? haddr[idx1] : '0;
    wr1_data_o = wr1_en_o ? hdata[idx1] : '0;
    wr2_addr_o = wr2_en_o ? haddr[idx2] : '0;
    wr2_data_o = wr2_en_o ? hdata[idx2] : '0;
    busy_o     = (|held) & ~rst;
  end

  // Buffer stage boundary: occupancy and priority pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      held   <= '0;
      rr_ptr <= '0;
    end else begin
      for (int s = 0; s < NUM_SRC; s++) begin
        if (accept[s]) begin
          held[s] <= 1'b1;
        end else if (grant[s] || (src_valid_i[s] && src_ready_o[s])) begin
          held[s] <= 1'b0;
        end
      end
      if (vld2) begin
        rr_ptr <= rr_next(idx2);
      end else if (vld1) begin
        rr_ptr <= rr_next(idx1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int s = 0; s < NUM_SRC; s++) begin
      if (accept[s]) begin
        haddr[s] <= in_addr[s];
        hdata[s] <= in_data[s];
      end
    end
  end

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Bench for rf_write_scheduler: directed scenarios plus randomized traffic
// checked against a slot-array reference model.
module tb_rf_write_scheduler;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NS = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NS-1:0]          src_valid;
  logic [NS-1:0]          src_ready;
  logic [NS-1:0][AW-1:0]  src_addr;
  logic [NS-1:0][DW-1:0]  src_data;
  logic                   wr1_en;
  logic [AW-1:0]          wr1_addr;
  logic [DW-1:0]          wr1_data;
  logic                   wr2_en;
  logic [AW-1:0]          wr2_addr;
  logic [DW-1:0]          wr2_data;
  logic                   busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rf_write_scheduler #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .NUM_SRC    (NS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .src_valid_i (src_valid),
    .src_ready_o (src_ready),
    .src_addr_i  (src_addr),
    .src_data_i  (src_data),
    .wr1_en_o    (wr1_en),
    .wr1_addr_o  (wr1_addr),
    .wr1_data_o  (wr1_data),
    .wr2_en_o    (wr2_en),
    .wr2_addr_o  (wr2_addr),
    .wr2_data_o  (wr2_data),
    .busy_o      (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    src_valid = '0;
    src_addr  = '0;
    src_data  = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({wr1_en, wr2_en, busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_outputs: en1/en2/busy=%b required 000", {wr1_en, wr2_en, busy});
    end
    checks++;
    if ({wr1_addr, wr1_data, wr2_addr, wr2_data} !== '0) begin
      errors++;
      $display("FAIL reset_addr_data: got nonzero %h %h %h %h required 0", wr1_addr, wr1_data, wr2_addr, wr2_data);
    end
    checks++;
    if (src_ready !== 4'hF) begin
      errors++;
      $display("FAIL reset_ready: got %b required 1111", src_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({src_ready, busy, wr1_en, wr2_en} !== 7'b1111_000) begin
      errors++;
      $display("FAIL post_reset_idle: ready/busy/en=%b required 1111000", {src_ready, busy, wr1_en, wr2_en});
    end
  endtask

  task automatic test_single();
    do_reset();
    src_valid    = 4'b0001;
    src_addr[0]  = 5'd5;
    src_data[0]  = 32'hDEADBEEF;
    #1;
    checks++;
    if (src_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL single_ready: got %b required 1", src_ready[0]);
    end
    tick();
    idle();
    #1;
    checks++;
    if ({wr1_en, wr1_addr, wr1_data} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL single_wr1: got en=%b addr=%0d data=%h required en=1 addr=5 data=deadbeef", wr1_en, wr1_addr, wr1_data);
    end
    checks++;
    if ({wr2_en, busy} !== 2'b01) begin
      errors++;
      $display("FAIL single_wr2_busy: got en2/busy=%b required 01", {wr2_en, busy});
    end
    tick();
    checks++;
    if ({wr1_en, wr2_en, busy} !== 3'b000) begin
      errors++;
      $display("FAIL single_drain: en1/en2/busy=%b required 000", {wr1_en, wr2_en, busy});
    end
  endtask

  task automatic test_four();
    do_reset();
    src_valid = 4'b1111;
    for (int s = 0; s < NS; s++) begin
      src_addr[s] = AW'(s + 1);
      src_data[s] = DW'(32'h100 + s);
    end
    tick();
    idle();
    #1;
    checks++;
    if ({wr1_en, wr1_addr, wr1_data, wr2_en, wr2_addr, wr2_data} !==
        {1'b1, 5'd1, 32'h100, 1'b1, 5'd2, 32'h101}) begin
      errors++;
      $display("FAIL four_c1: got %b/%0d/%h %b/%0d/%h required 1/1/100 1/2/101", wr1_en, wr1_addr, wr1_data, wr2_en, wr2_addr, wr2_data);
    end
    checks++;
    if (src_ready !== 4'b0011) begin
      errors++;
      $display("FAIL four_ready_c1: got %b required 0011 (src0,src1 ready)", src_ready);
    end
    tick();
    checks++;
    if ({wr1_en, wr1_addr, wr1_data, wr2_en, wr2_addr, wr2_data} !==
        {1'b1, 5'd3, 32'h102, 1'b1, 5'd4, 32'h103}) begin
      errors++;
      $display("FAIL four_c2: got %b/%0d/%h %b/%0d/%h required 1/3/102 1/4/103", wr1_en, wr1_addr, wr1_data, wr2_en, wr2_addr, wr2_data);
    end
    checks++;
    if (src_ready !== 4'b1111) begin
      errors++;
      $display("FAIL four_ready_c2: got %b required 1111", src_ready);
    end
    tick();
    checks++;
    if ({wr1_en, wr2_en, busy} !== 3'b000) begin
      errors++;
      $display("FAIL four_drain: en1/en2/busy=%b required 000", {wr1_en, wr2_en, busy});
    end
    // Pointer back at 0: src0 must outrank src3.
    src_valid   = 4'b1001;
    src_addr[0] = 5'd10;
    src_addr[3] = 5'd9;
    tick();
    idle();
    #1;
    checks++;
    if ({wr1_en, wr1_addr, wr2_en, wr2_addr} !== {1'b1, 5'd10, 1'b1, 5'd9}) begin
      errors++;
      $display("FAIL four_ptr_wrap: got %b/%0d %b/%0d required 1/10 1/9", wr1_en, wr1_addr, wr2_en, wr2_addr);
    end
    tick();
  endtask

  task automatic test_conflict();
    do_reset();
    src_valid   = 4'b0110;
    src_addr[1] = 5'd7;
    src_addr[2] = 5'd7;
    src_data[1] = 32'h11;
    src_data[2] = 32'h22;
    tick();
    idle();
    #1;
    checks++;
    if ({wr1_en, wr1_addr, wr1_data, wr2_en} !== {1'b1, 5'd7, 32'h11, 1'b0}) begin
      errors++;
      $display("FAIL conflict_c1: got %b/%0d/%h en2=%b required 1/7/11 en2=0", wr1_en, wr1_addr, wr1_data, wr2_en);
    end
    checks++;
    if (src_ready !== 4'b1011) begin
      errors++;
      $display("FAIL conflict_ready: got %b required 1011", src_ready);
    end
    tick();
    checks++;
    if ({wr1_en, wr1_addr, wr1_data, wr2_en} !== {1'b1, 5'd7, 32'h22, 1'b0}) begin
      errors++;
      $display("FAIL conflict_c2: got %b/%0d/%h en2=%b required 1/7/22 en2=0", wr1_en, wr1_addr, wr1_data, wr2_en);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL conflict_drain: busy=%b required 0", busy);
    end
  endtask

  task automatic test_x0();
    do_reset();
    src_valid   = 4'b1000;
    src_addr[3] = 5'd0;
    src_data[3] = 32'h1234;
    #1;
    checks++;
    if (src_ready[3] !== 1'b1) begin
      errors++;
      $display("FAIL x0_ready: got %b required 1", src_ready[3]);
    end
    tick();
    idle();
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if ({wr1_en, wr2_en, busy} !== 3'b000) begin
        errors++;
        $display("FAIL x0_no_write: cycle %0d en1/en2/busy=%b required 000", c, {wr1_en, wr2_en, busy});
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      src_valid   = 4'b0001;
      src_addr[0] = AW'(i + 1);
      src_data[0] = DW'(32'hA000 + i);
      #1;
      checks++;
      if (src_ready[0] !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready: beat %0d got %b required 1", i, src_ready[0]);
      end
      if (i > 0) begin
        checks++;
        if ({wr1_en, wr1_addr, wr1_data, wr2_en} !== {1'b1, AW'(i), DW'(32'hA000 + i - 1), 1'b0}) begin
          errors++;
          $display("FAIL b2b_write: beat %0d got %b/%0d/%h en2=%b required 1/%0d/%h en2=0", i, wr1_en, wr1_addr, wr1_data, wr2_en, i, 32'hA000 + i - 1);
        end
      end
      tick();
    end
    idle();
    #1;
    checks++;
    if ({wr1_en, wr1_addr, wr1_data} !== {1'b1, 5'd3, 32'hA002}) begin
      errors++;
      $display("FAIL b2b_last: got %b/%0d/%h required 1/3/a002", wr1_en, wr1_addr, wr1_data);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: busy=%b required 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    src_valid = 4'b0111;
    for (int s = 0; s < 3; s++) begin
      src_addr[s] = AW'(s + 4);
      src_data[s] = DW'(32'h5000 + s);
    end
    tick();
    idle();
    rst = 1'b1;
    #1;
    checks++;
    if ({wr1_en, wr2_en} !== 2'b00) begin
      errors++;
      $display("FAIL rstmid_during: en1/en2=%b required 00", {wr1_en, wr2_en});
    end
    checks++;
    if (src_ready !== 4'hF) begin
      errors++;
      $display("FAIL rstmid_ready_during: got %b required 1111", src_ready);
    end
    tick();
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if ({wr1_en, wr2_en, busy, src_ready} !== 7'b000_1111) begin
        errors++;
        $display("FAIL rstmid_after: cycle %0d en1/en2/busy/ready=%b required 0001111", c, {wr1_en, wr2_en, busy, src_ready});
      end
      tick();
    end
  endtask

  task automatic test_random();
    bit            m_held [NS];
    logic [AW-1:0] m_addr [NS];
    logic [DW-1:0] m_data [NS];
    int            m_ptr;
    int            e1;
    int            e2;
    int            s;
    logic [NS-1:0] exp_ready;
    logic [AW+DW:0] exp1;
    logic [AW+DW:0] exp2;
    do_reset();
    m_ptr = 0;
    for (int i = 0; i < NS; i++) begin
      m_held[i] = 1'b0;
      m_addr[i] = '0;
      m_data[i] = '0;
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < NS; i++) begin
        src_valid[i] = 1'($urandom_range(0, 1));
        src_addr[i]  = AW'($urandom_range(0, 7));
        src_data[i]  = $urandom;
      end
      #1;
      e1 = -1;
      e2 = -1;
      for (int k = 0; k < NS; k++) begin
        s = (m_ptr + k) % NS;
        if (m_held[s]) begin
          if (e1 < 0) e1 = s;
          else if (e2 < 0 && m_addr[s] != m_addr[e1]) e2 = s;
        end
      end
      for (int i = 0; i < NS; i++) exp_ready[i] = !m_held[i] || i == e1 || i == e2;
      exp1 = (e1 >= 0) ? {1'b1, m_addr[e1], m_data[e1]} : '0;
      exp2 = (e2 >= 0) ? {1'b1, m_addr[e2], m_data[e2]} : '0;
      checks++;
      if ({wr1_en, wr1_addr, wr1_data} !== exp1) begin
        errors++;
        $display("FAIL rand_wr1: cyc %0d got %h required %h", cyc, {wr1_en, wr1_addr, wr1_data}, exp1);
      end
      checks++;
      if ({wr2_en, wr2_addr, wr2_data} !== exp2) begin
        errors++;
        $display("FAIL rand_wr2: cyc %0d got %h required %h", cyc, {wr2_en, wr2_addr, wr2_data}, exp2);
      end
      checks++;
      if (src_ready !== exp_ready) begin
        errors++;
        $display("FAIL rand_ready: cyc %0d got %b required %b", cyc, src_ready, exp_ready);
      end
      checks++;
      if (busy !== (m_held[0] | m_held[1] | m_held[2] | m_held[3])) begin
        errors++;
        $display("FAIL rand_busy: cyc %0d got %b required %b", cyc, busy, m_held[0] | m_held[1] | m_held[2] | m_held[3]);
      end
      for (int i = 0; i < NS; i++) begin
        if (src_valid[i] && exp_ready[i]) begin
          m_held[i] = (src_addr[i] != 0);
          m_addr[i] = src_addr[i];
          m_data[i] = src_data[i];
        end else if (i == e1 || i == e2) begin
          m_held[i] = 1'b0;
        end
      end
      if (e2 >= 0) m_ptr = (e2 + 1) % NS;
      else if (e1 >= 0) m_ptr = (e1 + 1) % NS;
      tick();
    end
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_single();
    test_four();
    test_conflict();
    test_x0();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
